// File: rtl/timer_pkg.sv
// Shared encodings for the tick-driven timer: FSM states and mode constants.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_counter.sv
// Tick down-counter with reload register, terminal-count compare and
// zero detection of the load value.
module down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             sys_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             clear,
  input  logic             step,
  input  logic             periodic,
  output logic [CNT_W-1:0] count,
  output logic             last,
  output logic             load_zero
);

  logic [CNT_W-1:0] reload_reg;

  assign last      = (count == CNT_W'(1));
  assign load_zero = (load_value == '0);

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      count      <= '0;
      reload_reg <= '0;
    end else if (load) begin
      count      <= load_value;
      reload_reg <= load_value;
    end else if (clear) begin
      count <= '0;
    end else if (step) begin
      // terminal tick either reloads or parks at zero; never wraps
      if (last)
        count <= periodic ? reload_reg : '0;
      else if (count != '0)
        count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/param_timer.sv
// One-shot / periodic tick timer: FSM, mode latch and output pulses around
// a down_counter.
//
//   state     | meaning
//   ----------+---------------------------------------------
//   ST_IDLE   | no count active, remaining held at 0
//   ST_RUN    | counting down one per enable tick
//   ST_PAUSED | count frozen while pause is high
module param_timer
  import timer_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int PERIODIC_EN = 1
) (
  input  logic             clk,
  input  logic             sys_reset,
  input  logic             enable,
  input  logic             start_timer,
  input  logic [CNT_W-1:0] input_value,
  input  logic             mode,
  input  logic             pause,
  input  logic             abort,
  output logic             expired,
  output logic             divider_reset,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  state_t state;
  logic   mode_q;
  logic   clr_cnt;
  logic   step_cnt;
  logic   cnt_last;
  logic   cnt_load_zero;

  // priority start > abort > pause > enable is encoded in these enables
  assign clr_cnt  = !start_timer && abort && (state != ST_IDLE);
  assign step_cnt = !start_timer && !abort && !pause && enable && (state == ST_RUN);

  down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .sys_reset  (sys_reset),
    .load       (start_timer),
    .load_value (input_value),
    .clear      (clr_cnt),
    .step       (step_cnt),
    .periodic   (mode_q == MODE_PERIODIC),
    .count      (remaining),
    .last       (cnt_last),
    .load_zero  (cnt_load_zero)
  );

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state         <= ST_IDLE;
      mode_q        <= MODE_ONESHOT;
      expired       <= 1'b0;
      divider_reset <= 1'b0;
      busy          <= 1'b0;
    end else begin
      expired       <= 1'b0;
      divider_reset <= 1'b0;
      if (start_timer) begin
        divider_reset <= 1'b1;
        mode_q        <= (PERIODIC_EN != 0) ? mode : MODE_ONESHOT;
        if (cnt_load_zero) begin
          expired <= 1'b1;
          state   <= ST_IDLE;
          busy    <= 1'b0;
        end else begin
          state <= pause ? ST_PAUSED : ST_RUN;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          ST_RUN: begin
            if (abort) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (pause) begin
              state <= ST_PAUSED;
            end else if (enable && cnt_last) begin
              expired <= 1'b1;
              if (mode_q == MODE_ONESHOT) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          ST_PAUSED: begin
            if (abort) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (!pause) begin
              state <= ST_RUN;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_timer.sv
// Scoreboard bench for param_timer: expected output snapshots are queued with
// the cycle they belong to and compared by a negedge monitor.
module tb_param_timer;
  import timer_pkg::*;

  logic       clk = 1'b0;
  logic       sys_reset = 1'b1;
  logic       enable = 1'b0;
  logic       start_timer = 1'b0;
  logic [7:0] input_value = 8'd0;
  logic       mode = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       expired;
  logic       divider_reset;
  logic       busy;
  logic [7:0] remaining;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_exp = 0;
  int n_dr = 0;

  typedef struct {
    string      tag;
    int         cyc;
    logic       e;
    logic       dr;
    logic       b;
    logic [7:0] rem;
  } exp_t;

  exp_t sb_q[$];

  param_timer #(.CNT_W(8), .PERIODIC_EN(1)) dut (
    .clk           (clk),
    .sys_reset     (sys_reset),
    .enable        (enable),
    .start_timer   (start_timer),
    .input_value   (input_value),
    .mode          (mode),
    .pause         (pause),
    .abort         (abort),
    .expired       (expired),
    .divider_reset (divider_reset),
    .busy          (busy),
    .remaining     (remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // monitor: pulse counters plus scoreboard compare
  always @(negedge clk) begin
    if (expired === 1'b1) n_exp++;
    if (divider_reset === 1'b1) n_dr++;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t x;
      x = sb_q.pop_front();
      check({x.tag, ".cyc"}, cyc, x.cyc);
      check({x.tag, ".expired"}, expired, x.e);
      check({x.tag, ".div_rst"}, divider_reset, x.dr);
      check({x.tag, ".busy"}, busy, x.b);
      check({x.tag, ".remaining"}, remaining, x.rem);
    end
  end

  task automatic push(input string tag, input logic e, input logic dr, input logic b,
                      input logic [7:0] rem);
    exp_t x;
    x.tag = tag; x.cyc = cyc + 1; x.e = e; x.dr = dr; x.b = b; x.rem = rem;
    sb_q.push_back(x);
  endtask

  task automatic do_start(input string tag, input logic [7:0] val, input logic md,
                          input logic en, input logic e, input logic dr,
                          input logic b, input logic [7:0] rem);
    push(tag, e, dr, b, rem);
    start_timer = 1'b1; input_value = val; mode = md; enable = en;
    @(negedge clk);
    start_timer = 1'b0; enable = 1'b0;
    input_value = 8'hA5; mode = ~md;  // must not disturb the running count
  endtask

  task automatic drive_tick(input string tag, input logic e, input logic b,
                            input logic [7:0] rem);
    repeat (3) @(negedge clk);
    push(tag, e, 1'b0, b, rem);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic idle_check(input string tag, input logic b, input logic [7:0] rem);
    push(tag, 1'b0, 1'b0, b, rem);
    @(negedge clk);
  endtask

  task automatic do_abort(input string tag);
    push(tag, 1'b0, 1'b0, 1'b0, 8'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic snap(output int e, output int dr);
    #2;
    e = n_exp; dr = n_dr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected end", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0, e1, d1;
    repeat (2) @(negedge clk);
    push("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    sys_reset = 1'b0;
    idle_check("reset_rel", 1'b0, 8'd0);

    // 1: one-shot 2, enable in start cycle ignored
    snap(e0, d0);
    do_start("s1_start", 8'd2, MODE_ONESHOT, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
    drive_tick("s1_t1", 1'b0, 1'b1, 8'd1);
    drive_tick("s1_t2", 1'b1, 1'b0, 8'd0);
    idle_check("s1_after", 1'b0, 8'd0);
    drive_tick("s1_idle_tick", 1'b0, 1'b0, 8'd0);
    snap(e1, d1);
    check("s1_exp_count", e1 - e0, 1);
    check("s1_dr_count", d1 - d0, 1);

    // 2: periodic 3, three expiries, single divider_reset
    snap(e0, d0);
    do_start("s2_start", 8'd3, MODE_PERIODIC, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
    for (int p = 0; p < 3; p++) begin
      drive_tick("s2_a", 1'b0, 1'b1, 8'd2);
      drive_tick("s2_b", 1'b0, 1'b1, 8'd1);
      drive_tick("s2_exp", 1'b1, 1'b1, 8'd3);
    end
    do_abort("s2_abort");
    snap(e1, d1);
    check("s2_exp_count", e1 - e0, 3);
    check("s2_dr_count", d1 - d0, 1);

    // 3: pause across two ticks
    snap(e0, d0);
    do_start("s3_start", 8'd6, MODE_ONESHOT, 1'b0, 1'b0, 1'b1, 1'b1, 8'd6);
    drive_tick("s3_t1", 1'b0, 1'b1, 8'd5);
    drive_tick("s3_t2", 1'b0, 1'b1, 8'd4);
    pause = 1'b1;
    drive_tick("s3_p1", 1'b0, 1'b1, 8'd4);
    drive_tick("s3_p2", 1'b0, 1'b1, 8'd4);
    pause = 1'b0;
    drive_tick("s3_t3", 1'b0, 1'b1, 8'd3);
    drive_tick("s3_t4", 1'b0, 1'b1, 8'd2);
    drive_tick("s3_t5", 1'b0, 1'b1, 8'd1);
    drive_tick("s3_t6", 1'b1, 1'b0, 8'd0);
    snap(e1, d1);
    check("s3_exp_count", e1 - e0, 1);

    // 4: abort mid-count, abort in IDLE, restart
    snap(e0, d0);
    do_start("s4_start", 8'd5, MODE_ONESHOT, 1'b0, 1'b0, 1'b1, 1'b1, 8'd5);
    drive_tick("s4_t1", 1'b0, 1'b1, 8'd4);
    drive_tick("s4_t2", 1'b0, 1'b1, 8'd3);
    do_abort("s4_abort");
    drive_tick("s4_post", 1'b0, 1'b0, 8'd0);
    do_abort("s4_idle_abort");
    snap(e1, d1);
    check("s4_no_expire", e1 - e0, 0);
    do_start("s4_restart", 8'd3, MODE_ONESHOT, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
    drive_tick("s4_r1", 1'b0, 1'b1, 8'd2);
    drive_tick("s4_r2", 1'b0, 1'b1, 8'd1);
    drive_tick("s4_r3", 1'b1, 1'b0, 8'd0);

    // 5: zero duration, periodic mode requested
    do_start("s5_start", 8'd0, MODE_PERIODIC, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    idle_check("s5_after", 1'b0, 8'd0);
    drive_tick("s5_tick", 1'b0, 1'b0, 8'd0);

    // 6: reset mid-count with coincident start
    do_start("s6_start", 8'd6, MODE_PERIODIC, 1'b0, 1'b0, 1'b1, 1'b1, 8'd6);
    drive_tick("s6_t1", 1'b0, 1'b1, 8'd5);
    drive_tick("s6_t2", 1'b0, 1'b1, 8'd4);
    push("s6_reset", 1'b0, 1'b0, 1'b0, 8'd0);
    sys_reset = 1'b1; start_timer = 1'b1; input_value = 8'd9;
    @(negedge clk);
    sys_reset = 1'b0; start_timer = 1'b0;
    idle_check("s6_post", 1'b0, 8'd0);
    drive_tick("s6_idle_tick", 1'b0, 1'b0, 8'd0);
    do_start("s6_restart", 8'd2, MODE_ONESHOT, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2);
    drive_tick("s6_r1", 1'b0, 1'b1, 8'd1);
    drive_tick("s6_r2", 1'b1, 1'b0, 8'd0);

    repeat (2) @(negedge clk);
    #2;
    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_timer.md
PARAM_TIMER -- requirements
Module: param_timer

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of input_value, remaining and the internal reload register (legal range 2..16).
REQ-002 Parameter PERIODIC_EN, default 1, SHALL enable periodic mode when 1; when 0, mode is ignored and the block is one-shot only.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 sys_reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 enable  input  1  SHALL be the divider tick, one clk cycle wide, and SHALL cause one decrement per cycle asserted.
REQ-006 start_timer  input  1  SHALL be a one-cycle request to load input_value and start counting.
REQ-007 input_value  input  CNT_W  SHALL give the duration in ticks, sampled only in the start_timer cycle.
REQ-008 mode  input  1  SHALL select one-shot (0) or periodic auto-reload (1), sampled only in the start_timer cycle.
REQ-009 pause  input  1  SHALL be a level that freezes the count while high.
REQ-010 abort  input  1  SHALL be a one-cycle request to cancel without expiry.
REQ-011 expired  output  1  SHALL be a registered, one-cycle pulse at each expiry.
REQ-012 divider_reset  output  1  SHALL be a registered, one-cycle pulse that realigns the external tick divider.
REQ-013 busy  output  1  SHALL be high in RUN and PAUSED.
REQ-014 remaining  output  CNT_W  SHALL show the registered count of remaining ticks.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and PAUSED.
REQ-016 start_timer in any state SHALL, at the next edge: load remaining and reload_reg with input_value; latch mode (forced to 0 when PERIODIC_EN=0); pulse divider_reset; enter RUN (or PAUSED if pause=1).
REQ-017 An enable in the start_timer cycle SHALL be ignored, so the first decrement comes from the first tick after start.
REQ-018 start_timer with input_value=0 SHALL pulse expired and divider_reset in the same following cycle and enter IDLE, regardless of mode.
REQ-019 In RUN with enable=1, pause=0 and remaining>1, remaining SHALL decrement by 1.
REQ-020 In RUN with enable=1, pause=0 and remaining=1, the block SHALL pulse expired at the next edge, then:
  - one-shot: set remaining=0 and enter IDLE;
  - periodic: reload remaining from reload_reg and stay in RUN.
REQ-021 A periodic reload SHALL NOT pulse divider_reset.
REQ-022 pause=1 in RUN SHALL move to PAUSED; pause=0 in PAUSED SHALL return to RUN; ticks SHALL be ignored while pause=1.
REQ-023 abort in RUN or PAUSED SHALL set remaining=0 and enter IDLE, with no expired pulse; abort in IDLE SHALL have no effect.
REQ-024 Same-cycle priority SHALL be: sys_reset > start_timer > abort > pause > enable.
REQ-025 An abort coincident with the final tick SHALL suppress expired.
REQ-026 Changes to input_value or mode outside the start cycle SHALL NOT affect a running count.
REQ-027 In IDLE, enable SHALL have no effect and remaining SHALL hold 0.
REQ-028 remaining SHALL never wrap below 0.

Reset
REQ-029 sys_reset SHALL force IDLE, remaining=0, reload_reg=0, mode latch=0, expired=0, divider_reset=0 and busy=0 at the next edge, including mid-count or while paused.
REQ-030 start_timer coincident with sys_reset SHALL be discarded.

Structure
REQ-031 The state encoding (IDLE/RUN/PAUSED) and the mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1) SHALL live in a shared package, timer_pkg.
REQ-032 Decrement, reload and zero detection SHALL be a single sub-module, down_counter, parametrised by CNT_W; the FSM and output pulses SHALL stay in param_timer.

Verification
REQ-033 The bench SHALL cover these scenarios (CNT_W=8, tick every 4 clk):
  1. One-shot, input_value=2 -> divider_reset pulse 1 cycle after start; remaining 2,1; expired 1 cycle after the 2nd tick; busy low afterwards.
  2. Periodic, input_value=3 -> expired after ticks 3, 6 and 9; remaining reloads to 3 each time; only one divider_reset pulse.
  3. input_value=6, pause high across 2 ticks after tick 2 -> remaining holds 4; expired after the 6th unpaused tick.
  4. input_value=5, abort after tick 2 -> remaining=0, IDLE, no expired; then restart with input_value=3 -> expires after 3 ticks.
  5. input_value=0 -> expired and divider_reset pulse together 1 cycle after start; busy never high.
  6. sys_reset mid-count (remaining=4) -> all outputs 0 at the next edge; a start_timer coincident with sys_reset is ignored; a later start works normally.
